// File: rtl/interleaver_ctrl.sv
// Ping-pong bank sequencer for a bit interleaver: linear writes into one bank while the other is read out.
// INTERLEAVER_CTRL_STATS_EN adds the Sym_Count completed-symbol counter; without it Sym_Count is tied to 0.
module interleaver_ctrl #(
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        mode_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              wr_en_o,
    output logic              wr_bank_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              rd_en_o,
    output logic              rd_bank_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              sym_start_o,
    output logic              sym_end_o,
    output logic [15:0]       sym_count_o
);
    typedef enum logic {R_IDLE, R_READ} rd_state_e;

    function automatic logic [ADDR_W-1:0] last_idx(input logic [1:0] m);
        case (m)
            2'd0:    last_idx = ADDR_W'(47);
            2'd1:    last_idx = ADDR_W'(95);
            2'd2:    last_idx = ADDR_W'(191);
            default: last_idx = ADDR_W'(287);
        endcase
    endfunction

    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic [1:0][1:0]   mode_q, mode_d;
    logic              out_valid_q, out_valid_d;
    logic              sym_start_q, sym_start_d, sym_end_q, sym_end_d;
    rd_state_e         state_q, state_d;

    logic       accept, wr_last, rd_last;
    logic [1:0] wr_mode;

    assign in_ready_o = !rst_i && !full_q[wr_bank_q];
    assign accept     = in_valid_i && in_ready_o;
    // The first bit of a symbol uses the live Mode; later bits use the mode latched for this bank.
    assign wr_mode    = (wr_cnt_q == '0) ? mode_i : mode_q[wr_bank_q];
    assign wr_last    = accept && (wr_cnt_q == last_idx(wr_mode));
    assign rd_en_o    = !rst_i && (state_q == R_READ) && (!out_valid_q || out_ready_i);
    assign rd_last    = rd_en_o && (rd_cnt_q == last_idx(mode_q[rd_bank_q]));

    assign wr_en_o     = accept;
    assign wr_bank_o   = wr_bank_q;
    assign wr_addr_o   = wr_cnt_q;
    assign rd_bank_o   = rd_bank_q;
    assign rd_addr_o   = rd_cnt_q;
    assign out_valid_o = out_valid_q;
    assign sym_start_o = sym_start_q;
    assign sym_end_o   = sym_end_q;

    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        full_d      = full_q;
        mode_d      = mode_q;
        rd_cnt_d    = rd_cnt_q;
        rd_bank_d   = rd_bank_q;
        out_valid_d = out_valid_q;
        sym_start_d = sym_start_q;
        sym_end_d   = sym_end_q;
        if (accept) begin
            if (wr_cnt_q == '0) mode_d[wr_bank_q] = mode_i;
            if (wr_last) begin
                wr_cnt_d          = '0;
                wr_bank_d         = ~wr_bank_q;
                full_d[wr_bank_q] = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + ADDR_W'(1);
            end
        end
        // Writer only touches an empty bank and reader only a full one, so these never collide.
        if (rd_en_o) begin
            out_valid_d = 1'b1;
            sym_start_d = (rd_cnt_q == '0);
            sym_end_d   = rd_last;
            if (rd_last) begin
                rd_cnt_d          = '0;
                rd_bank_d         = ~rd_bank_q;
                full_d[rd_bank_q] = 1'b0;
            end else begin
                rd_cnt_d = rd_cnt_q + ADDR_W'(1);
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
            sym_start_d = 1'b0;
            sym_end_d   = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            R_IDLE:  if (full_d[rd_bank_d]) state_d = R_READ;
            R_READ:  if (rd_last && !full_d[rd_bank_d]) state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            full_q      <= '0;
            mode_q      <= '0;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            out_valid_q <= 1'b0;
            sym_start_q <= 1'b0;
            sym_end_q   <= 1'b0;
            state_q     <= R_IDLE;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            full_q      <= full_d;
            mode_q      <= mode_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            out_valid_q <= out_valid_d;
            sym_start_q <= sym_start_d;
            sym_end_q   <= sym_end_d;
            state_q     <= state_d;
        end
    end

`ifdef INTERLEAVER_CTRL_STATS_EN
    logic [15:0] sym_count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sym_count_q <= '0;
        end else if (sym_end_q && out_valid_q && out_ready_i) begin
            sym_count_q <= sym_count_q + 16'd1;
        end
    end

    assign sym_count_o = sym_count_q;
`else
    assign sym_count_o = '0;
`endif

endmodule

// File: tb/tb_interleaver_ctrl.sv
// Directed bench for interleaver_ctrl: reset/accept vector table plus multi-symbol sequences.
module tb_interleaver_ctrl;
    localparam int AW = 9;

    logic          clk;
    logic          rst;
    logic [1:0]    mode;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic          rd_bank;
    logic [AW-1:0] rd_addr;
    logic          out_valid;
    logic          out_ready;
    logic          sym_start;
    logic          sym_end;
    logic [15:0]   sym_count;

    interleaver_ctrl #(.ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .wr_en_o(wr_en), .wr_bank_o(wr_bank), .wr_addr_o(wr_addr),
        .rd_en_o(rd_en), .rd_bank_o(rd_bank), .rd_addr_o(rd_addr),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .sym_start_o(sym_start), .sym_end_o(sym_end), .sym_count_o(sym_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: entries are bank*1000 + address.
    int wr_q[$];
    int rd_q[$];
    int out_q[$];
    bit st_q[$];
    bit en_q[$];
    int stall = 0;
    int pend  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && !in_ready) stall++;
            if (wr_en) wr_q.push_back(int'(wr_bank) * 1000 + int'(wr_addr));
            if (out_valid && out_ready) begin
                out_q.push_back(pend);
                st_q.push_back(sym_start);
                en_q.push_back(sym_end);
            end
            if (rd_en) begin
                rd_q.push_back(int'(rd_bank) * 1000 + int'(rd_addr));
                pend = int'(rd_bank) * 1000 + int'(rd_addr);
            end
        end
    end

    function automatic int bad_lin(input int which, input int n);
        int bad;
        int sz;
        int v;
        bad = 0;
        sz  = (which == 0) ? wr_q.size() : (which == 1) ? rd_q.size() : out_q.size();
        for (int i = 0; i < sz; i++) begin
            v = (which == 0) ? wr_q[i] : (which == 1) ? rd_q[i] : out_q[i];
            if (v != ((i / n) % 2) * 1000 + (i % n)) bad++;
        end
        return bad;
    endfunction

    function automatic int bad_flags(input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < out_q.size(); i++)
            if (st_q[i] != (i % n == 0) || en_q[i] != (i % n == n - 1)) bad++;
        return bad;
    endfunction

    function automatic int n_ends();
        int c;
        c = 0;
        for (int i = 0; i < en_q.size(); i++) if (en_q[i]) c++;
        return c;
    endfunction

    function automatic int q_at(input int which, input int idx);
        if (which == 0) return (idx < wr_q.size()) ? wr_q[idx] : -1;
        if (which == 1) return (idx < rd_q.size()) ? rd_q[idx] : -1;
        if (which == 2) return (idx < out_q.size()) ? out_q[idx] : -1;
        return (idx < en_q.size()) ? int'(en_q[idx]) : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_q.delete();
        rd_q.delete();
        out_q.delete();
        st_q.delete();
        en_q.delete();
        stall = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mode      = 2'd0;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic set_ordy(input int pat, input int cyc);
        if (pat == 0)      out_ready = 1'b1;
        else if (pat == 1) out_ready = 1'b0;
        else               out_ready = (cyc % 2 == 1);
    endtask

    // Feed nbits with In_Valid held high; Mode switches from m0 to m1 once sw bits are accepted.
    task automatic run(input int nbits, input int m0, input int m1, input int sw,
                       input int pat, input int drain);
        int cyc;
        cyc = 0;
        while (wr_q.size() < nbits && cyc < 4000) begin
            mode     = (wr_q.size() < sw) ? 2'(m0) : 2'(m1);
            in_valid = 1'b1;
            set_ordy(pat, cyc);
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("feed_budget", wr_q.size(), nbits);
        for (int i = 0; i < drain; i++) begin
            set_ordy(pat, cyc + i);
            tick();
        end
    endtask

    typedef struct {
        bit rst;
        bit iv;
        bit ordy;
        int m;
        int e_rdy;
        int e_wen;
        int e_waddr;
        int e_wbank;
        int e_ren;
        int e_ov;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int exp_cnt;
        // -1 marks a don't-care expectation
        vecs[0] = '{1, 1, 1, 0, 0, 0, -1, -1, 0, -1};
        vecs[1] = '{1, 1, 1, 0, 0, 0,  0,  0, 0,  0};
        vecs[2] = '{0, 1, 1, 0, 1, 1,  0,  0, 0,  0};
        vecs[3] = '{0, 0, 1, 0, 1, 0,  1,  0, 0,  0};
        vecs[4] = '{0, 1, 1, 0, 1, 1,  1,  0, 0,  0};
        vecs[5] = '{0, 1, 1, 3, 1, 1,  2,  0, 0,  0};
        vecs[6] = '{1, 1, 1, 0, 0, 0, -1, -1, 0, -1};
        vecs[7] = '{0, 0, 1, 0, 1, 0,  0,  0, 0,  0};
        vecs[8] = '{0, 1, 1, 1, 1, 1,  0,  0, 0,  0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'd0;
        for (int i = 0; i < 9; i++) begin
            rst = vecs[i].rst; in_valid = vecs[i].iv; out_ready = vecs[i].ordy; mode = 2'(vecs[i].m);
            @(negedge clk);
            if (vecs[i].e_rdy   >= 0) chk($sformatf("vec%0d_in_ready", i), int'(in_ready), vecs[i].e_rdy);
            if (vecs[i].e_wen   >= 0) chk($sformatf("vec%0d_wr_en", i), int'(wr_en), vecs[i].e_wen);
            if (vecs[i].e_waddr >= 0) chk($sformatf("vec%0d_wr_addr", i), int'(wr_addr), vecs[i].e_waddr);
            if (vecs[i].e_wbank >= 0) chk($sformatf("vec%0d_wr_bank", i), int'(wr_bank), vecs[i].e_wbank);
            if (vecs[i].e_ren   >= 0) chk($sformatf("vec%0d_rd_en", i), int'(rd_en), vecs[i].e_ren);
            if (vecs[i].e_ov    >= 0) chk($sformatf("vec%0d_out_valid", i), int'(out_valid), vecs[i].e_ov);
            tick();
        end

        // One Mode-2 symbol, free-flowing output
        do_reset();
        run(192, 2, 2, 0, 0, 300);
        chk("m2_wr_seq_bad", bad_lin(0, 192), 0);
        chk("m2_rd_cnt", rd_q.size(), 192);
        chk("m2_rd_seq_bad", bad_lin(1, 192), 0);
        chk("m2_out_cnt", out_q.size(), 192);
        chk("m2_flags_bad", bad_flags(192), 0);
        @(negedge clk);
        chk("m2_idle_in_ready", int'(in_ready), 1);
        chk("m2_idle_out_valid", int'(out_valid), 0);

        // Three back-to-back Mode-2 symbols at full rate
        do_reset();
        run(576, 2, 2, 0, 0, 700);
        chk("stream_stalls", stall, 0);
        chk("stream_wr_bad", bad_lin(0, 192), 0);
        chk("stream_rd_bad", bad_lin(1, 192), 0);
        chk("stream_out_cnt", out_q.size(), 576);
        chk("stream_ends", n_ends(), 3);
`ifdef INTERLEAVER_CTRL_STATS_EN
        exp_cnt = 3;
`else
        exp_cnt = 0;
`endif
        chk("stream_sym_count", int'(sym_count), exp_cnt);

        // Mode 0 with downstream stalled: both banks fill, output holds on address 0
        do_reset();
        run(96, 0, 0, 0, 1, 0);
        in_valid = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("hold_in_ready", int'(in_ready), 0);
        chk("hold_accepts", wr_q.size(), 96);
        chk("hold_out_valid", int'(out_valid), 1);
        chk("hold_rd_issued", rd_q.size(), 1);
        chk("hold_rd0", q_at(1, 0), 0);
        chk("hold_no_beats", out_q.size(), 0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (300) tick();
        chk("resume_rd1", q_at(1, 1), 1);
        chk("resume_out0", q_at(2, 0), 0);
        chk("resume_out_cnt", out_q.size(), 96);
        chk("resume_out_bad", bad_lin(2, 48), 0);

        // Mode change mid-symbol applies only to the next symbol
        do_reset();
        run(384, 1, 3, 50, 0, 900);
        chk("mchg_wr95", q_at(0, 95), 95);
        chk("mchg_wr96", q_at(0, 96), 1000);
        chk("mchg_wr383", q_at(0, 383), 1287);
        chk("mchg_out_cnt", out_q.size(), 384);
        chk("mchg_ends", n_ends(), 2);
        chk("mchg_end95", q_at(3, 95), 1);
        chk("mchg_end383", q_at(3, 383), 1);

        // Reset with bank 0 mid-read and bank 1 partially written
        do_reset();
        run(292, 2, 2, 0, 0, 0);
        rst = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        tick();
        @(negedge clk);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_bank", int'(wr_bank), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_rd_bank", int'(rd_bank), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sym_start", int'(sym_start), 0);
        chk("rst_sym_end", int'(sym_end), 0);
        chk("rst_sym_count", int'(sym_count), 0);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        clear_logs();
        @(negedge clk);
        chk("rst_release_in_ready", int'(in_ready), 1);
        tick();
        run(192, 2, 2, 0, 0, 300);
        chk("rst_next_wr0", q_at(0, 0), 0);
        chk("rst_next_wr_bad", bad_lin(0, 192), 0);
        chk("rst_next_out_cnt", out_q.size(), 192);
        chk("rst_next_out_bad", bad_lin(2, 192), 0);

        // Mode 3 with Out_Ready toggling every cycle
        do_reset();
        run(288, 3, 3, 0, 2, 800);
        chk("tog_rd_cnt", rd_q.size(), 288);
        chk("tog_rd_bad", bad_lin(1, 288), 0);
        chk("tog_out_cnt", out_q.size(), 288);
        chk("tog_out_bad", bad_lin(2, 288), 0);
        chk("tog_flags_bad", bad_flags(288), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1, "timeout");
    end

endmodule
